// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: fetch/decode/exec/mem/wb sequencer for the shared RV32I datapath with a memory watchdog
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] Op,
    input  logic [2:0] funct3,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemtoReg,
    output logic       ALUSrc,
    output logic [1:0] regSel,
    output logic [1:0] ALUOp,
    output logic [2:0] state_o,
    output logic       instret,
    output logic       illegal,
    output logic       fault
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        FAULT  = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        C_BR    = 3'd0,
        C_R     = 3'd1,
        C_I     = 3'd2,
        C_LD    = 3'd3,
        C_ST    = 3'd4,
        C_LUI   = 3'd5,
        C_AUIPC = 3'd6
    } cls_t;

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    state_t     state_q, state_d;
    cls_t       cls_q, cls_d, dec_cls;
    logic [7:0] cnt_q, cnt_d;
    logic       dec_ok, taken, timed_out, is_ld, is_st;

    // Opcode to instruction class; unknown opcodes flag dec_ok low
    always_comb begin
        dec_ok  = 1'b1;
        dec_cls = C_R;
        case (Op)
            7'b1100011: dec_cls = C_BR;
            7'b0110011: dec_cls = C_R;
            7'b0010011: dec_cls = C_I;
            7'b0000011: dec_cls = C_LD;
            7'b0100011: dec_cls = C_ST;
            7'b0110111: dec_cls = C_LUI;
            7'b0010111: dec_cls = C_AUIPC;
            default:    dec_ok  = 1'b0;
        endcase
    end

    // Next state, watchdog count and all control outputs; reset masks every output to 0
    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        cnt_d   = cnt_q;
        {mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSrc, RegWrite, MemtoReg,
         ALUSrc, regSel, ALUOp, instret, illegal, fault} = '0;
        state_o   = state_q;
        is_ld     = cls_q == C_LD;
        is_st     = cls_q == C_ST;
        taken     = (funct3 == 3'b000 && Zero) || (funct3 == 3'b001 && !Zero);
        timed_out = TIMEOUT != 8'd0 && cnt_q == TIMEOUT && !mem_ready;
        if (state_q inside {EXEC, MEM, WB}) begin
            ALUSrc = cls_q inside {C_I, C_LD, C_ST, C_LUI, C_AUIPC};
            ALUOp  = cls_q == C_R ? 2'b10 : cls_q == C_I ? 2'b11 : cls_q == C_BR ? 2'b01 : 2'b00;
            regSel = cls_q == C_LUI ? 2'b01 : cls_q == C_AUIPC ? 2'b10 : 2'b00;
        end
        case (state_q)
            FETCH: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                state_d = mem_ready ? DECODE : timed_out ? FAULT : FETCH;
            end
            DECODE: begin
                illegal = !dec_ok;
                cls_d   = dec_ok ? dec_cls : cls_q;
                state_d = dec_ok ? EXEC : FETCH;
            end
            EXEC: begin
                PCWrite = cls_q == C_BR && taken;
                PCSrc   = cls_q == C_BR && taken;
                instret = cls_q == C_BR;
                state_d = cls_q == C_BR ? FETCH : (is_ld || is_st) ? MEM : WB;
            end
            MEM: begin
                mem_req  = 1'b1;
                IorD     = 1'b1;
                MemRead  = is_ld;
                MemWrite = is_st;
                instret  = is_st && mem_ready;
                state_d  = mem_ready ? (is_st ? FETCH : WB) : timed_out ? FAULT : MEM;
            end
            WB: begin
                RegWrite = 1'b1;
                MemtoReg = is_ld;
                instret  = 1'b1;
                state_d  = FETCH;
            end
            FAULT: begin
                fault = 1'b1;
            end
            default: state_d = FETCH;
        endcase
        if (state_d != state_q && (state_d == FETCH || state_d == MEM))
            cnt_d = 8'd0;
        else if (mem_req && !mem_ready)
            cnt_d = cnt_q + 8'd1;
        if (reset)
            {mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSrc, RegWrite, MemtoReg,
             ALUSrc, regSel, ALUOp, state_o, instret, illegal, fault} = '0;
    end

    // State, latched instruction class and watchdog counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            cls_q   <= C_BR;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle sequencer for the RV32I core. It steps the shared datapath (one ALU, one unified memory port, register file) through fetch, decode, execute, memory and writeback for each instruction. It drives the same control fields the main decoder defines: regSel, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite and ALUOp. It also owns the PC/IR write enables and the memory request handshake, and it has a timeout watchdog on memory.

## Interface
- MEM_TIMEOUT, default 255: maximum wait cycles for mem_ready (8-bit counter); 0 disables the watchdog.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- Op  in  7  opcode field from IR.
- funct3  in  3  funct3 field from IR.
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request valid.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead, MemWrite  out  1 each  memory direction.
- IRWrite  out  1  latch IR and OldPC.
- PCWrite  out  1  PC load enable.
- PCSrc  out  1  PC source: 0 = PC+4, 1 = branch target.
- RegWrite, MemtoReg, ALUSrc  out  1 each  main-decoder meaning.
- regSel  out  2  main-decoder meaning: 00 normal, 01 imm/zero, 10 imm/PC.
- ALUOp  out  2  main-decoder meaning.
- state_o  out  3  current state for debug.
- instret  out  1  one-cycle pulse when an instruction retires.
- illegal  out  1  one-cycle pulse when an unknown opcode is seen in DECODE.
- fault  out  1  sticky memory-timeout indication.

## Operation
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=7.
- **FETCH**
  - Drives mem_req=1, MemRead=1, IorD=0.
  - When mem_ready=1: IRWrite=1, PCWrite=1, PCSrc=0, then go to DECODE. Otherwise stay in FETCH.
- **DECODE**
  - Registers the instruction class from Op/funct3: BR, R, I, LD, ST, LUI, AUIPC.
  - Any other opcode pulses illegal and returns to FETCH. It is not retired.
  - Every other class goes to EXEC.
- **Class-driven fields in EXEC, MEM and WB** (held constant across all three states):
  - R: ALUOp=10.
  - I: ALUSrc=1, ALUOp=11.
  - LD/ST: ALUSrc=1, ALUOp=00.
  - BR: ALUOp=01.
  - LUI: ALUSrc=1, regSel=01.
  - AUIPC: ALUSrc=1, regSel=10.
- **EXEC**
  - BR: the branch is taken if (funct3=000 and Zero) or (funct3=001 and !Zero). Any other funct3 is never taken. If taken, drive PCWrite=1, PCSrc=1. Pulse instret and go to FETCH.
  - R, I, LUI, AUIPC: go to WB.
  - LD, ST: go to MEM.
- **MEM**
  - Drives mem_req=1, IorD=1, with MemRead=1 for LD or MemWrite=1 for ST.
  - When mem_ready=1: ST pulses instret and goes to FETCH; LD goes to WB. The datapath latches MDR on mem_ready.
- **WB**
  - Drives RegWrite=1, with MemtoReg=1 for LD and 0 otherwise.
  - Pulses instret and goes to FETCH.
- **Watchdog**
  - The counter clears on entry to FETCH or MEM.
  - It increments each cycle that mem_req=1 and mem_ready=0.
  - When it reaches MEM_TIMEOUT with mem_ready still 0, the next state is FAULT.
  - mem_ready=1 in the same cycle the count reaches MEM_TIMEOUT wins: normal progress, no fault.
- **FAULT**
  - All outputs are 0 except fault=1 and state_o=7.
  - The block stays in FAULT until reset.
- Outputs not listed for a state are 0.

## Timing
- **Reset**
  - While reset=1: state=FETCH, counter=0, class=0, and every output is forced 0, including mem_req.
  - The first cycle after deassertion is FETCH with mem_req=1.
  - Reset asserted mid-instruction aborts it immediately, with no retire and no write enables.
- **Output timing**
  - Outputs are combinational from the registered state, the class, mem_ready and Zero.
  - All state transitions occur on the rising clock edge.
- **Cycles per instruction with zero-wait memory** (mem_ready=1 on the request cycle):
  - BR: 3.
  - R, I, LUI, AUIPC: 4.
  - ST: 4.
  - LD: 5.
  - Each memory wait cycle adds 1.
- **Pulse timing**
  - instret is high for exactly one cycle, the final cycle of the instruction.
  - illegal is high for exactly the DECODE cycle.
- **Handshake rules**
  - mem_req, IorD, MemRead and MemWrite stay stable from assertion until the cycle in which mem_ready=1.
  - mem_ready is ignored outside FETCH and MEM.

## Test plan
- Reset, then R-type (Op=0110011) with mem_ready held at 1 → state_o sequence 0,1,2,4,0; RegWrite=1 only in WB; ALUOp=10 in EXEC; instret pulses in WB.
- beq (funct3=000) with Zero=1, then with Zero=0 → first case: PCWrite=1, PCSrc=1 in EXEC; second case: PCWrite=0 in EXEC; both retire after 3 cycles.
- Load with mem_ready low for 3 cycles in MEM → MemRead, IorD and mem_req held for 4 cycles; WB drives MemtoReg=1, RegWrite=1; 8 cycles total.
- Store, then opcode 1111111 → store retires in 4 cycles with MemWrite=1 only in MEM; the illegal opcode pulses illegal in DECODE, returns to FETCH, and instret does not fire.
- MEM_TIMEOUT=4 with mem_ready held at 0 in FETCH → FAULT after 5 cycles in FETCH; fault=1 and all enables 0; stays in FAULT; reset returns to FETCH.
- Reset pulsed during MEM of a store → MemWrite drops immediately; state_o=0 after release; no instret.
